// File: rtl/sram_tx_frame_reader.sv
// sram_tx_frame_reader: pulls sync/length/payload words for one transmit frame
// out of the shared SRAM FIFO and hands the stream bytes to the radio TX path,
// one byte per tx_valid/tx_ready handshake.
module sram_tx_frame_reader #(
   parameter logic [15:0] SYNC_WORD    = 16'h2DD4,
   parameter int          WAIT_TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tx_enable,
   output logic        SRAM_read,
   input  logic        SRAM_hint,
   input  logic [15:0] Data_from_sram,
   input  logic        SRAM_empty,
   output logic [7:0]  tx_len,
   output logic        tx_start,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        tx_done,
   output logic        tx_busy,
   output logic        frame_err,
   output logic [15:0] frames_sent,
   output logic [7:0]  err_count
);

   localparam int CW = $clog2(WAIT_TIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE,
      RD_SYNC,
      WAIT_SYNC,
      RD_LEN,
      WAIT_LEN,
      RD_DATA,
      WAIT_DATA,
      SEND_HI,
      SEND_LO,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic          sram_read_q, sram_read_d;
   logic [15:0]   word_q, word_d;
   logic [8:0]    remaining_q, remaining_d;
   logic [7:0]    tx_len_q, tx_len_d;
   logic          tx_start_q, tx_start_d;
   logic [7:0]    tx_byte_q, tx_byte_d;
   logic          tx_valid_q, tx_valid_d;
   logic          tx_done_q, tx_done_d;
   logic          tx_busy_q, tx_busy_d;
   logic          frame_err_q, frame_err_d;
   logic [15:0]   frames_sent_q, frames_sent_d;
   logic [7:0]    err_count_q, err_count_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          err_req;
   logic          wait_expired;
   logic [CW-1:0] wait_cnt_inc;
   logic [7:0]    err_count_sat;

   assign wait_expired  = (wait_cnt_q == CW'(WAIT_TIMEOUT - 1));
   assign wait_cnt_inc  = wait_cnt_q + 1'b1;
   assign err_count_sat = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

   // Next-state and next-output logic; any error request overrides the case
   // result and returns the reader to IDLE with the SRAM and radio handshakes dropped.
   always_comb begin
      state_d       = state_q;
      sram_read_d   = sram_read_q;
      word_d        = word_q;
      remaining_d   = remaining_q;
      tx_len_d      = tx_len_q;
      tx_start_d    = 1'b0;
      tx_byte_d     = tx_byte_q;
      tx_valid_d    = tx_valid_q;
      tx_done_d     = 1'b0;
      frame_err_d   = 1'b0;
      frames_sent_d = frames_sent_q;
      err_count_d   = err_count_q;
      wait_cnt_d    = '0;
      err_req       = 1'b0;

      case (state_q)
         IDLE: begin
            if (tx_enable && !SRAM_empty) begin
               state_d = RD_SYNC;
            end
         end

         RD_SYNC: begin
            if (!SRAM_empty) begin
               sram_read_d = 1'b1;
               state_d     = WAIT_SYNC;
            end
         end

         WAIT_SYNC: begin
            if (SRAM_hint) begin
               sram_read_d = 1'b0;
               if (Data_from_sram == SYNC_WORD) begin
                  state_d = RD_LEN;
               end else begin
                  err_req = 1'b1;
               end
            end else if (wait_expired) begin
               err_req = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_inc;
            end
         end

         RD_LEN: begin
            if (!SRAM_empty) begin
               sram_read_d = 1'b1;
               state_d     = WAIT_LEN;
            end
         end

         WAIT_LEN: begin
            if (SRAM_hint) begin
               sram_read_d = 1'b0;
               if (Data_from_sram[7:0] == 8'd0) begin
                  err_req = 1'b1;
               end else begin
                  tx_len_d    = Data_from_sram[7:0];
                  tx_start_d  = 1'b1;
                  remaining_d = {1'b0, Data_from_sram[7:0]};
                  state_d     = RD_DATA;
               end
            end else if (wait_expired) begin
               err_req = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_inc;
            end
         end

         RD_DATA: begin
            if (!SRAM_empty) begin
               sram_read_d = 1'b1;
               state_d     = WAIT_DATA;
            end else if (wait_expired) begin
               err_req = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_inc;
            end
         end

         WAIT_DATA: begin
            if (SRAM_hint) begin
               sram_read_d = 1'b0;
               word_d      = Data_from_sram;
               state_d     = SEND_HI;
            end else if (wait_expired) begin
               err_req = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_inc;
            end
         end

         SEND_HI: begin
            if (!tx_valid_q) begin
               tx_valid_d = 1'b1;
               tx_byte_d  = word_q[15:8];
            end else if (tx_ready) begin
               tx_valid_d  = 1'b0;
               remaining_d = remaining_q - 9'd1;
               state_d     = (remaining_q == 9'd1) ? DONE : SEND_LO;
            end
         end

         SEND_LO: begin
            if (!tx_valid_q) begin
               tx_valid_d = 1'b1;
               tx_byte_d  = word_q[7:0];
            end else if (tx_ready) begin
               tx_valid_d  = 1'b0;
               remaining_d = remaining_q - 9'd1;
               state_d     = (remaining_q == 9'd1) ? DONE : RD_DATA;
            end
         end

         DONE: begin
            tx_done_d     = 1'b1;
            frames_sent_d = frames_sent_q + 16'd1;
            state_d       = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (err_req) begin
         sram_read_d = 1'b0;
         tx_valid_d  = 1'b0;
         frame_err_d = 1'b1;
         err_count_d = err_count_sat;
         state_d     = IDLE;
         wait_cnt_d  = '0;
      end

      tx_busy_d = (state_d != IDLE);
   end

   // Register state, counters and every output so the radio and SRAM see glitch-free signals.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         sram_read_q   <= 1'b0;
         word_q        <= 16'd0;
         remaining_q   <= 9'd0;
         tx_len_q      <= 8'd0;
         tx_start_q    <= 1'b0;
         tx_byte_q     <= 8'd0;
         tx_valid_q    <= 1'b0;
         tx_done_q     <= 1'b0;
         tx_busy_q     <= 1'b0;
         frame_err_q   <= 1'b0;
         frames_sent_q <= 16'd0;
         err_count_q   <= 8'd0;
         wait_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         sram_read_q   <= sram_read_d;
         word_q        <= word_d;
         remaining_q   <= remaining_d;
         tx_len_q      <= tx_len_d;
         tx_start_q    <= tx_start_d;
         tx_byte_q     <= tx_byte_d;
         tx_valid_q    <= tx_valid_d;
         tx_done_q     <= tx_done_d;
         tx_busy_q     <= tx_busy_d;
         frame_err_q   <= frame_err_d;
         frames_sent_q <= frames_sent_d;
         err_count_q   <= err_count_d;
         wait_cnt_q    <= wait_cnt_d;
      end
   end

   assign SRAM_read   = sram_read_q;
   assign tx_len      = tx_len_q;
   assign tx_start    = tx_start_q;
   assign tx_byte     = tx_byte_q;
   assign tx_valid    = tx_valid_q;
   assign tx_done     = tx_done_q;
   assign tx_busy     = tx_busy_q;
   assign frame_err   = frame_err_q;
   assign frames_sent = frames_sent_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_sram_tx_frame_reader.sv
// tb_sram_tx_frame_reader: directed frames through a queue-backed SRAM model,
// with a scoreboard of expected lengths and bytes checked as the radio side accepts them.
module tb_sram_tx_frame_reader;

   localparam int WAIT_TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tx_enable = 1'b0;
   logic        SRAM_read;
   logic        SRAM_hint = 1'b0;
   logic [15:0] Data_from_sram = 16'd0;
   logic        SRAM_empty = 1'b1;
   logic [7:0]  tx_len;
   logic        tx_start;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        tx_done;
   logic        tx_busy;
   logic        frame_err;
   logic [15:0] frames_sent;
   logic [7:0]  err_count;

   int asserts  = 0;
   int failures = 0;

   logic [15:0] sram_q[$];
   logic [7:0]  exp_bytes[$];
   logic [7:0]  exp_lens[$];

   int          done_cnt  = 0;
   int          start_cnt = 0;
   int          err_cnt   = 0;
   logic [15:0] exp_frames = 16'd0;
   logic [7:0]  exp_err    = 8'd0;

   sram_tx_frame_reader #(
      .SYNC_WORD    (16'h2DD4),
      .WAIT_TIMEOUT (WAIT_TIMEOUT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .tx_enable      (tx_enable),
      .SRAM_read      (SRAM_read),
      .SRAM_hint      (SRAM_hint),
      .Data_from_sram (Data_from_sram),
      .SRAM_empty     (SRAM_empty),
      .tx_len         (tx_len),
      .tx_start       (tx_start),
      .tx_byte        (tx_byte),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .tx_done        (tx_done),
      .tx_busy        (tx_busy),
      .frame_err      (frame_err),
      .frames_sent    (frames_sent),
      .err_count      (err_count)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Overall watchdog so a stuck design can never hang the run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      asserts++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] word);
      sram_q.push_back(word);
   endtask

   task automatic expectByte(input logic [7:0] b);
      exp_bytes.push_back(b);
   endtask

   task automatic expectLen(input logic [7:0] l);
      exp_lens.push_back(l);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic waitIdle(input string tag, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick(1);
         if (sram_q.size() == 0 && !tx_busy && exp_bytes.size() == 0) ok = 1'b1;
      end
      checkOutput(tag, 32'(ok), 32'd1);
      tick(3);
   endtask

   task automatic waitValid(input string tag, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick(1);
         if (tx_valid) ok = 1'b1;
      end
      checkOutput(tag, 32'(ok), 32'd1);
   endtask

   // SRAM model: answers a pending read with a one-cycle hint carrying the
   // next queued word, and reports empty whenever the queue has drained.
   always @(negedge clk) begin
      if (SRAM_hint) begin
         SRAM_hint = 1'b0;
      end else if (SRAM_read && sram_q.size() > 0) begin
         SRAM_hint      = 1'b1;
         Data_from_sram = sram_q.pop_front();
      end
      SRAM_empty = (sram_q.size() == 0);
   end

   // Scoreboard monitor: compares accepted and held bytes, tx_len at each
   // start, and the frame/error counters at each done/error pulse.
   always @(negedge clk) begin
      if (reset) begin
         exp_frames = 16'd0;
         exp_err    = 8'd0;
      end else begin
         if (tx_valid && tx_ready) begin
            if (exp_bytes.size() == 0) checkOutput("byte_unexpected", 32'(exp_bytes.size()), 32'd1);
            else checkOutput("tx_byte", 32'(tx_byte), 32'(exp_bytes.pop_front()));
         end else if (tx_valid && exp_bytes.size() > 0) begin
            checkOutput("held_byte", 32'(tx_byte), 32'(exp_bytes[0]));
         end
         if (tx_start) begin
            start_cnt++;
            if (exp_lens.size() == 0) checkOutput("start_unexpected", 32'(exp_lens.size()), 32'd1);
            else checkOutput("tx_len", 32'(tx_len), 32'(exp_lens.pop_front()));
         end
         if (tx_done) begin
            done_cnt++;
            exp_frames = exp_frames + 16'd1;
            checkOutput("frames_sent", 32'(frames_sent), 32'(exp_frames));
         end
         if (frame_err) begin
            err_cnt++;
            if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
            checkOutput("err_count", 32'(err_count), 32'(exp_err));
         end
      end
   end

   // Directed sequence of frames, stalls, timeout and mid-frame reset.
   initial begin
      tick(3);
      checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
      checkOutput("rst_tx_busy", 32'(tx_busy), 32'd0);
      checkOutput("rst_sram_read", 32'(SRAM_read), 32'd0);
      checkOutput("rst_frames_sent", 32'(frames_sent), 32'd0);
      checkOutput("rst_err_count", 32'(err_count), 32'd0);
      checkOutput("rst_tx_len", 32'(tx_len), 32'd0);
      reset     = 1'b0;
      tx_enable = 1'b1;
      tx_ready  = 1'b1;
      tick(2);
      checkOutput("idle_no_read", 32'(SRAM_read), 32'd0);

      // Even-length frame
      applyStimulus(16'h2DD4); applyStimulus(16'h0004);
      applyStimulus(16'h03AA); applyStimulus(16'hBBCC);
      expectLen(8'd4);
      expectByte(8'h03); expectByte(8'hAA); expectByte(8'hBB); expectByte(8'hCC);
      waitIdle("frame1_idle", 200);
      checkOutput("frame1_done_cnt", 32'(done_cnt), 32'd1);
      checkOutput("frame1_frames_sent", 32'(frames_sent), 32'd1);
      checkOutput("frame1_tx_len", 32'(tx_len), 32'd4);

      // Odd-length frame, pad byte must not appear
      applyStimulus(16'h2DD4); applyStimulus(16'h0003);
      applyStimulus(16'h02AA); applyStimulus(16'hBB00);
      expectLen(8'd3);
      expectByte(8'h02); expectByte(8'hAA); expectByte(8'hBB);
      waitIdle("frame2_idle", 200);
      checkOutput("frame2_done_cnt", 32'(done_cnt), 32'd2);
      checkOutput("frame2_frames_sent", 32'(frames_sent), 32'd2);

      // Bad sync word followed by a good frame
      applyStimulus(16'h1234); applyStimulus(16'h2DD4);
      applyStimulus(16'h0002); applyStimulus(16'h01EE);
      expectLen(8'd2);
      expectByte(8'h01); expectByte(8'hEE);
      waitIdle("frame3_idle", 200);
      checkOutput("frame3_err_cnt", 32'(err_cnt), 32'd1);
      checkOutput("frame3_err_count", 32'(err_count), 32'd1);
      checkOutput("frame3_done_cnt", 32'(done_cnt), 32'd3);

      // Zero-length frame
      applyStimulus(16'h2DD4); applyStimulus(16'h0000);
      waitIdle("frame4_idle", 200);
      checkOutput("frame4_err_cnt", 32'(err_cnt), 32'd2);
      checkOutput("frame4_err_count", 32'(err_count), 32'd2);
      checkOutput("frame4_start_cnt", 32'(start_cnt), 32'd3);

      // Radio stall for 20 cycles with the first byte presented
      tx_ready = 1'b0;
      applyStimulus(16'h2DD4); applyStimulus(16'h0002); applyStimulus(16'h05A1);
      expectLen(8'd2);
      expectByte(8'h05); expectByte(8'hA1);
      waitValid("stall_valid_wait", 100);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         checkOutput("stall_tx_byte", 32'(tx_byte), 32'h05);
         checkOutput("stall_tx_valid", 32'(tx_valid), 32'd1);
      end
      tx_ready = 1'b1;
      waitIdle("stall_idle", 200);
      checkOutput("stall_done_cnt", 32'(done_cnt), 32'd4);

      // FIFO runs dry after the length word: timeout abort
      applyStimulus(16'h2DD4); applyStimulus(16'h0004);
      expectLen(8'd4);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 200 && !seen; i++) begin
            tick(1);
            if (err_cnt == 3) seen = 1'b1;
         end
         checkOutput("timeout_err_seen", 32'(seen), 32'd1);
      end
      tick(2);
      checkOutput("timeout_tx_busy", 32'(tx_busy), 32'd0);
      checkOutput("timeout_sram_read", 32'(SRAM_read), 32'd0);
      checkOutput("timeout_done_cnt", 32'(done_cnt), 32'd4);
      checkOutput("timeout_err_count", 32'(err_count), 32'd3);
      checkOutput("timeout_start_cnt", 32'(start_cnt), 32'd5);

      // Reset while the low byte of a word is being presented
      tx_ready = 1'b0;
      applyStimulus(16'h2DD4); applyStimulus(16'h0004);
      applyStimulus(16'h1122); applyStimulus(16'h3344);
      expectLen(8'd4);
      expectByte(8'h11); expectByte(8'h22); expectByte(8'h33); expectByte(8'h44);
      waitValid("rst_frame_hi_wait", 100);
      tx_ready = 1'b1;
      tick(1);
      tx_ready = 1'b0;
      waitValid("rst_frame_lo_wait", 100);
      checkOutput("rst_frame_lo_byte", 32'(tx_byte), 32'h22);
      reset = 1'b1;
      tick(1);
      checkOutput("midrst_tx_valid", 32'(tx_valid), 32'd0);
      checkOutput("midrst_tx_busy", 32'(tx_busy), 32'd0);
      checkOutput("midrst_tx_byte", 32'(tx_byte), 32'd0);
      checkOutput("midrst_tx_len", 32'(tx_len), 32'd0);
      checkOutput("midrst_frames_sent", 32'(frames_sent), 32'd0);
      checkOutput("midrst_err_count", 32'(err_count), 32'd0);
      checkOutput("midrst_sram_read", 32'(SRAM_read), 32'd0);
      exp_bytes.delete();
      tick(2);
      reset    = 1'b0;
      tx_ready = 1'b1;

      // Leftover word 0x3344 is consumed as a failed sync attempt
      waitIdle("resync_idle", 200);
      checkOutput("resync_err_cnt", 32'(err_cnt), 32'd4);
      checkOutput("resync_err_count", 32'(err_count), 32'd1);
      checkOutput("resync_done_cnt", 32'(done_cnt), 32'd4);
      checkOutput("resync_frames_sent", 32'(frames_sent), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule

// File: doc/sram_tx_frame_reader.md
Name: sram_tx_frame_reader

Overview:
- Drains host-written transmit frames from the shared SRAM FIFO and feeds them byte-by-byte to the Si4463 radio TX path.
- Frame format in SRAM, one 16-bit word per entry:
  - word0: sync 0x2DD4.
  - word1: {0x00, L}.
  - Next ceil(L/2) words: L stream bytes, packed high byte first. The first stream byte is the host payload length (L-1). If L is odd, the final low byte is 0x00 padding.
- Sits between the SRAM controller's read port and the radio TX controller. It also supplies frame length and start/done strobes to the radio controller.

Parameters:
- SYNC_WORD, 16'h2DD4, required first word of every frame.
- WAIT_TIMEOUT, 65535, max cycles waiting on a mid-frame SRAM_empty or on SRAM_hint before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tx_enable  in  1  permits starting a new frame; sampled only in IDLE.
- SRAM_read  out  1  read request; held high until SRAM_hint.
- SRAM_hint  in  1  one-cycle read-complete strobe; Data_from_sram is valid in this same cycle.
- Data_from_sram  in  16  read data.
- SRAM_empty  in  1  FIFO empty.
- tx_len  out  8  stream byte count L; valid from tx_start until tx_done.
- tx_start  out  1  one-cycle pulse: L latched, first byte follows.
- tx_byte  out  8  byte to radio.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  radio accepts byte when tx_valid&&tx_ready.
- tx_done  out  1  one-cycle pulse after last byte accepted.
- tx_busy  out  1  high in every state except IDLE.
- frame_err  out  1  one-cycle pulse on sync error, L==0, or timeout.
- frames_sent  out  16  completed-frame counter; wraps.
- err_count  out  8  error counter; saturates at 255.

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE. Reset mid-frame abandons the frame immediately with no tx_done or frame_err. Remaining SRAM words are consumed later by resync.
- SRAM read handshake:
  - Assert SRAM_read only when !SRAM_empty.
  - Capture data in the SRAM_hint cycle.
  - SRAM_read is low the cycle after hint.
  - Never more than one outstanding read.
- IDLE: if tx_enable && !SRAM_empty, go to RD_SYNC.
- RD_SYNC, then WAIT_SYNC:
  - Word == SYNC_WORD: go to RD_LEN.
  - Otherwise: frame_err pulse, err_count++ (saturating), return to IDLE. This discards one word per attempt, i.e. resync.
- RD_LEN, then WAIT_LEN:
  - L = word[7:0]; word[15:8] is ignored.
  - L==0: frame_err, err_count++, return to IDLE.
  - Otherwise: latch tx_len=L, pulse tx_start, remaining=L, go to RD_DATA.
- RD_DATA: wait while SRAM_empty, counting cycles. After reading a word, go to SEND_HI.
- SEND_HI:
  - tx_byte=word[15:8], tx_valid=1; hold stable until tx_ready.
  - On accept, remaining--.
  - Then: remaining==0 → DONE; otherwise → SEND_LO.
- SEND_LO:
  - Same hold-until-ready rule with word[7:0].
  - Then: remaining==0 → DONE; otherwise → RD_DATA.
- Padding: the pad byte of an odd L is never presented.
- tx_valid drops in the cycle after acceptance; back-to-back bytes are not required.
- DONE: tx_done pulse, frames_sent++, go to IDLE. The next frame may start the following cycle.
- Timeout:
  - A wait counter runs in any WAIT_* state, or in RD_DATA while empty.
  - It resets on each state change.
  - Reaching WAIT_TIMEOUT: drop SRAM_read and tx_valid, pulse frame_err, err_count++, go to IDLE.
  - tx_ready stall is not timed.
- tx_enable low mid-frame has no effect; the frame completes.
- remaining is 9-bit internally so L=255 decrements correctly.

Test Plan:
- Frame 2DD4,0004,03AA,BBCC with tx_ready always high → tx_start, tx_len=4, bytes 03,AA,BB,CC, tx_done, frames_sent=1.
- Odd L: 2DD4,0003,02AA,BB00 → bytes 02,AA,BB only (pad dropped), tx_done once.
- Bad sync: 1234,2DD4,0002,01EE → one frame_err, err_count=1, then bytes 01,EE and tx_done.
- L=0 frame 2DD4,0000 → frame_err, no tx_start. tx_ready held low 20 cycles mid-frame → tx_byte stable, no bytes lost.
- FIFO empties after the length word for WAIT_TIMEOUT cycles (WAIT_TIMEOUT=16) → frame_err, tx_busy low, no tx_done. Reset asserted during SEND_LO → all outputs 0 next cycle.
